bgm_tone_decoder: RTL and testbench
===================================

// Module: bgm_tone_decoder
// PURPOSE
//  Receive side of the BGM square-wave audio path. Samples a square-wave tone line
//  (the audioOut format of the BGM player), measures half-periods and recovers each note
//  as (note_period, note_duration) in the player's own encoding: period in clk cycles
//  minus 1, duration in 1/16 s units. Used for loopback self-test and capture.
// PARAMETERS
//  CLK_FREQ     100_000_000  clk frequency in Hz; duration tick = CLK_FREQ/16 cycles
//  PERIOD_W     20           width of half-period counter and note_period
//  DUR_W        5            width of note_duration (saturating)
//  TOL          2            max |half-period change| (cycles) still counted as same note
//  MIN_HALF     4            accepted half-periods are >= MIN_HALF cycles; shorter = glitch
//  SILENCE_CYC  1_000_000    cycles without an edge that end a note (must be < 2^PERIOD_W)
// PORTS
//  clk            in   1         system clock
//  reset          in   1         active-low reset
//  listen         in   1         decode enable; mirrors player playSound
//  audio_in       in   1         asynchronous square-wave tone input
//  note_valid     out  1         1-cycle pulse: a completed note is presented
//  note_period    out  PERIOD_W  recovered period code (half-period cycles - 1)
//  note_duration  out  DUR_W     recovered duration, 1/16 s units
//  note_index     out  10        count of notes emitted, wraps 1023->0
//  glitch_cnt     out  8         only with BGM_DECODER_STATS_EN, see CONFIGURATION
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-low.
//  - Reset: every output is 0, FSM is IDLE, all counters are 0. Reset mid-note drops the note.
//  - audio_in passes through a 2-flop synchronizer; edge = any change of the synced bit.
//    Latency from pin to edge detect is 3 cycles; all timing is relative to the synced signal.
//  - half_cnt: +1 per cycle, saturates at 2^PERIOD_W-1, cleared on each accepted edge.
//    meas = half_cnt+1 at the edge (cycles since previous accepted edge).
//  - Glitch: edge with meas < MIN_HALF is discarded. half_cnt is not cleared.
//  - FSM IDLE: first edge -> ACQUIRE (half_cnt cleared).
//    ACQUIRE: accepted edge -> TRACK. cur_period = meas; note start.
//    TRACK: accepted edge with |meas-cur_period| <= TOL -> snapshot duration, stay.
//           accepted edge with |meas-cur_period| > TOL -> emit current note, new note starts
//           with cur_period = meas.
//    ACQUIRE/TRACK: half_cnt >= SILENCE_CYC and no edge this cycle -> TRACK emits the
//           current note; ACQUIRE emits nothing; both -> IDLE. An edge in the same cycle wins.
//  - Duration: at note start, tick_cnt is preset to CLK_FREQ/32 (round to nearest) and
//    dur_cnt is cleared. tick_cnt +1 per cycle; on reaching CLK_FREQ/16 it clears and
//    dur_cnt +1, saturating at 2^DUR_W-1. An emitted note uses the dur_cnt snapshot from
//    its last accepted edge.
//  - Emit: next cycle note_valid=1, note_period=cur_period-1, note_duration=snapshot,
//    note_index is incremented after presenting. Outputs hold until the next emit.
//    No backpressure.
//  - listen=0: synchronous clear to IDLE, counters 0. Note in progress is dropped,
//    no pulse. Registered outputs and note_index keep their values.
// CONFIGURATION
//  BGM_DECODER_STATS_EN defined: glitch_cnt port exists. It counts discarded edges,
//    saturates at 255, and is cleared only by reset.
//  Not defined: no glitch_cnt port and no counter logic. Decode behaviour is identical.
// TESTING (CLK_FREQ=1600 -> tick=100 cycles, SILENCE_CYC=64, other params default)
//  1 half-period 11 cyc for t=0..400, then 21 cyc to t=600, then static
//    -> pulse (period 10, dur 4, idx 0), then (period 20, dur 2, idx 1), then IDLE.
//  2 half-period 11 with one 2-cycle glitch pair at t=200 -> single note (10,4);
//    STATS build: glitch_cnt=2.
//  3 half-period 12/13/12 jitter (within TOL) for 300 cyc then silence
//    -> one note, period 11 or 12, dur 3.
//  4 half-period 11 for 4000 cyc then silence -> (10, 31): duration saturates.
//  5 listen dropped at t=250 mid-note, raised at t=300 with tone resumed
//    -> no pulse for the aborted note; the new note decodes normally.
//  6 reset asserted mid-note -> outputs 0 asynchronously, no pulse; idx restarts at 0.

Source files
------------

// File: rtl/bgm_tone_decoder.sv
// bgm_tone_decoder: recovers (period, duration) notes from a BGM square-wave tone line.
// Define BGM_DECODER_STATS_EN to add the glitch_cnt_o statistics port.

module bgm_tone_decoder #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int PERIOD_W    = 20,
  parameter int DUR_W       = 5,
  parameter int TOL         = 2,
  parameter int MIN_HALF    = 4,
  parameter int SILENCE_CYC = 1_000_000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                listen_i,
  input  logic                audio_in_i,
  output logic                note_valid_o,
  output logic [PERIOD_W-1:0] note_period_o,
  output logic [DUR_W-1:0]    note_duration_o,
  output logic [9:0]          note_index_o
`ifdef BGM_DECODER_STATS_EN
  ,
  output logic [7:0]          glitch_cnt_o
`endif
);

  localparam int TICK   = CLK_FREQ / 16;
  localparam int PRESET = (CLK_FREQ + 16) / 32;
  localparam int TICK_W = $clog2(TICK + 1);

  localparam logic [TICK_W-1:0]   TICK_LAST   = TICK_W'(TICK - 1);
  localparam logic [TICK_W-1:0]   TICK_PRESET = TICK_W'(PRESET);
  localparam logic [TICK_W-1:0]   TICK_ONE    = TICK_W'(1);
  localparam logic [PERIOD_W-1:0] HALF_MAX    = '1;
  localparam logic [PERIOD_W-1:0] HALF_ONE    = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] SILENCE_L   = PERIOD_W'(SILENCE_CYC);
  localparam logic [PERIOD_W:0]   MEAS_ONE    = (PERIOD_W + 1)'(1);
  localparam logic [PERIOD_W:0]   MIN_HALF_L  = (PERIOD_W + 1)'(MIN_HALF);
  localparam logic [PERIOD_W:0]   TOL_L       = (PERIOD_W + 1)'(TOL);
  localparam logic [DUR_W-1:0]    DUR_MAX     = '1;
  localparam logic [DUR_W-1:0]    DUR_ONE     = DUR_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    TRACK
  } state_e;

  logic                sync1_q, sync2_q, prev_q;
  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] half_q, half_d;
  logic [PERIOD_W-1:0] cur_q, cur_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [DUR_W-1:0]    snap_q, snap_d;
  logic                valid_q;
  logic [PERIOD_W-1:0] period_q;
  logic [DUR_W-1:0]    duration_q;
  logic [9:0]          index_q;

  logic                edge_w, glitch_w, accept_w, silence_w, emit_w, tick_wrap_w;
  logic [PERIOD_W:0]   meas_w, cur_ext_w, diff_w;
  logic [PERIOD_W-1:0] half_run_w;
  logic [TICK_W-1:0]   tick_run_w;
  logic [DUR_W-1:0]    dur_run_w;

  // Two-flop synchronizer plus a history flop for edge detection on the synced bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= audio_in_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_w      = sync2_q ^ prev_q;
  assign meas_w      = {1'b0, half_q} + MEAS_ONE;
  assign cur_ext_w   = {1'b0, cur_q};
  assign diff_w      = (meas_w >= cur_ext_w) ? (meas_w - cur_ext_w) : (cur_ext_w - meas_w);
  assign glitch_w    = edge_w && (state_q != IDLE) && (meas_w < MIN_HALF_L);
  assign accept_w    = edge_w && !glitch_w;
  assign silence_w   = !edge_w && (half_q >= SILENCE_L);
  assign half_run_w  = (half_q == HALF_MAX) ? half_q : half_q + HALF_ONE;
  assign tick_wrap_w = (tick_q == TICK_LAST);
  assign tick_run_w  = tick_wrap_w ? '0 : tick_q + TICK_ONE;
  assign dur_run_w   = (tick_wrap_w && (dur_q != DUR_MAX)) ? dur_q + DUR_ONE : dur_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      half_q  <= '0;
      cur_q   <= '0;
      tick_q  <= '0;
      dur_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      cur_q   <= cur_d;
      tick_q  <= tick_d;
      dur_q   <= dur_d;
      snap_q  <= snap_d;
    end
  end

  // A new note presets the tick counter half a tick in, so durations round to nearest.
  always_comb begin
    state_d = state_q;
    half_d  = half_run_w;
    cur_d   = cur_q;
    tick_d  = tick_run_w;
    dur_d   = dur_run_w;
    snap_d  = snap_q;
    emit_w  = 1'b0;
    if (!listen_i) begin
      state_d = IDLE;
      half_d  = '0;
      cur_d   = '0;
      tick_d  = '0;
      dur_d   = '0;
      snap_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          half_d = '0;
          cur_d  = '0;
          tick_d = '0;
          dur_d  = '0;
          snap_d = '0;
          if (edge_w) begin
            state_d = ACQUIRE;
          end
        end
        ACQUIRE: begin
          tick_d = '0;
          dur_d  = '0;
          if (accept_w) begin
            state_d = TRACK;
            half_d  = '0;
            cur_d   = meas_w[PERIOD_W-1:0];
            tick_d  = TICK_PRESET;
            snap_d  = '0;
          end else if (silence_w) begin
            state_d = IDLE;
          end
        end
        TRACK: begin
          if (accept_w) begin
            half_d = '0;
            if (diff_w <= TOL_L) begin
              snap_d = dur_run_w;
            end else begin
              emit_w = 1'b1;
              cur_d  = meas_w[PERIOD_W-1:0];
              tick_d = TICK_PRESET;
              dur_d  = '0;
              snap_d = '0;
            end
          end else if (silence_w) begin
            emit_w  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The note index advances the cycle after a pulse, so the pulse shows the note's own index.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= 1'b0;
      period_q   <= '0;
      duration_q <= '0;
      index_q    <= '0;
    end else begin
      valid_q <= emit_w;
      if (emit_w) begin
        period_q   <= cur_q - HALF_ONE;
        duration_q <= snap_q;
      end
      index_q <= index_q + {9'b0, valid_q};
    end
  end

  assign note_valid_o    = valid_q;
  assign note_period_o   = period_q;
  assign note_duration_o = duration_q;
  assign note_index_o    = index_q;

`ifdef BGM_DECODER_STATS_EN
  logic [7:0] glitch_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      glitch_q <= '0;
    end else if (listen_i && glitch_w && (glitch_q != 8'hFF)) begin
      glitch_q <= glitch_q + 8'd1;
    end
  end

  assign glitch_cnt_o = glitch_q;
`endif

endmodule

// File: tb/tb_bgm_tone_decoder.sv
// Testbench for bgm_tone_decoder: directed tone scenarios plus random tones, checked every
// cycle against a time-based note model.

module tb_bgm_tone_decoder;

  localparam int CLK_FREQ = 1600;
  localparam int PERIOD_W = 20;
  localparam int DUR_W    = 5;
  localparam int TOL      = 2;
  localparam int MIN_HALF = 4;
  localparam int SIL      = 64;
  localparam int TICK     = CLK_FREQ / 16;
  localparam int PRESET   = (CLK_FREQ + 16) / 32;
  localparam int DUR_SAT  = (1 << DUR_W) - 1;
  localparam int M_IDLE   = 0;
  localparam int M_ACQ    = 1;
  localparam int M_TRACK  = 2;

  typedef struct {
    int period;
    int dur;
    int idx;
  } note_t;

  logic                clk = 1'b0;
  logic                rstN = 1'b0;
  logic                listen = 1'b0;
  logic                audioIn = 1'b0;
  logic                noteValid;
  logic [PERIOD_W-1:0] notePeriod;
  logic [DUR_W-1:0]    noteDuration;
  logic [9:0]          noteIndex;
`ifdef BGM_DECODER_STATS_EN
  logic [7:0]          glitchCnt;
`endif

  int checks = 0;
  int errors = 0;
  note_t dutNotes[$];

  bit         h0, h1, h2;
  int         mState = M_IDLE;
  int         cyc = 0;
  int         lastAcc = 0;
  int         curP = 0;
  int         noteStart = 0;
  int         lastEdge = 0;
  bit         mValid = 1'b0;
  int         mPeriod = 0;
  int         mDur = 0;
  logic [9:0] mIdx = '0;
  int         mGlitch = 0;

  bgm_tone_decoder #(
    .CLK_FREQ(CLK_FREQ),
    .PERIOD_W(PERIOD_W),
    .DUR_W(DUR_W),
    .TOL(TOL),
    .MIN_HALF(MIN_HALF),
    .SILENCE_CYC(SIL)
  ) dut (
    .clk_i(clk),
    .rst_ni(rstN),
    .listen_i(listen),
    .audio_in_i(audioIn),
    .note_valid_o(noteValid),
    .note_period_o(notePeriod),
    .note_duration_o(noteDuration),
    .note_index_o(noteIndex)
`ifdef BGM_DECODER_STATS_EN
    ,
    .glitch_cnt_o(glitchCnt)
`endif
  );

  always #5 clk = ~clk;

  // Duration in 1/16 s ticks, rounded to nearest, saturating.
  function automatic int durOf(input int d);
    int v;
    v = (d + PRESET) / TICK;
    return (v > DUR_SAT) ? DUR_SAT : v;
  endfunction

  task automatic emitNote();
    mValid  = 1'b1;
    mPeriod = curP - 1;
    mDur    = durOf(lastEdge - noteStart);
  endtask

  // The synced line lags the pin by two samples; an edge is a change between those delayed samples.
  task automatic modelStep();
    bit eg;
    int meas;
    int df;
    if (!rstN) begin
      h0 = 0; h1 = 0; h2 = 0;
      mState = M_IDLE; mValid = 0; mPeriod = 0; mDur = 0; mIdx = '0; mGlitch = 0;
    end else begin
      eg = (h1 != h2);
      h2 = h1; h1 = h0; h0 = audioIn;
      meas = cyc - lastAcc;
      if (mValid) mIdx = mIdx + 10'd1;
      mValid = 0;
      if (!listen) begin
        mState = M_IDLE;
      end else if (mState == M_IDLE) begin
        if (eg) begin
          mState = M_ACQ;
          lastAcc = cyc;
        end
      end else if (eg && meas < MIN_HALF) begin
        if (mGlitch < 255) mGlitch++;
      end else if (eg) begin
        lastAcc = cyc;
        if (mState == M_ACQ) begin
          mState = M_TRACK; curP = meas; noteStart = cyc; lastEdge = cyc;
        end else begin
          df = meas - curP;
          if (df < 0) df = -df;
          if (df <= TOL) begin
            lastEdge = cyc;
          end else begin
            emitNote();
            curP = meas; noteStart = cyc; lastEdge = cyc;
          end
        end
      end else if (meas - 1 >= SIL) begin
        if (mState == M_TRACK) emitNote();
        mState = M_IDLE;
      end
    end
    cyc++;
  endtask

  task automatic compareOutputs();
    bit bad;
    checks++;
    bad = (noteValid !== mValid) || (notePeriod !== PERIOD_W'(mPeriod)) ||
          (noteDuration !== DUR_W'(mDur)) || (noteIndex !== mIdx);
`ifdef BGM_DECODER_STATS_EN
    bad = bad || (glitchCnt !== 8'(mGlitch));
`endif
    if (bad) begin
      errors++;
      $display("[TB] FAIL cycle %0d outputs: got v=%b p=%0d d=%0d i=%0d expected v=%b p=%0d d=%0d i=%0d",
               cyc, noteValid, notePeriod, noteDuration, noteIndex, mValid, mPeriod, mDur, mIdx);
    end
    if (noteValid === 1'b1) dutNotes.push_back('{int'(notePeriod), int'(noteDuration), int'(noteIndex)});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      modelStep();
      @(negedge clk);
      if (rstN) compareOutputs();
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkNote(input string name, input int k, input int p, input int d, input int i);
    if (k >= dutNotes.size()) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got %0d notes expected note #%0d", name, dutNotes.size(), k);
    end else begin
      checkOutput({name, " period"}, dutNotes[k].period, p);
      checkOutput({name, " duration"}, dutNotes[k].dur, d);
      checkOutput({name, " index"}, dutNotes[k].idx, i);
    end
  endtask

  task automatic waitToggle(input int n);
    repeat (n) @(posedge clk);
    #1 audioIn = ~audioIn;
  endtask

  task automatic playTone(input int hp, input int len);
    int t;
    t = 0;
    while (t + hp <= len) begin
      waitToggle(hp);
      t += hp;
    end
  endtask

  task automatic settle();
    repeat (150) @(posedge clk);
    #1;
  endtask

  // One random segment: jittered tone, occasional glitch pairs and listen drop, then a gap.
  task automatic applyStimulus();
    int hp, jit, len, t, h, gap;
    bit glitchy, drop;
    hp      = int'($urandom_range(30, 4));
    jit     = int'($urandom_range(3, 0));
    len     = int'($urandom_range(600, 40));
    glitchy = ($urandom_range(3, 0) == 0);
    drop    = ($urandom_range(5, 0) == 0);
    t = 0;
    while (t < len) begin
      h = hp - jit + int'($urandom_range(2 * jit, 0));
      if (h < 1) h = 1;
      if (glitchy && h > 4 && $urandom_range(7, 0) == 0) begin
        waitToggle(1);
        waitToggle(2);
        h -= 3;
      end
      waitToggle(h);
      t += hp;
      listen = !(drop && t >= len / 2 && t < (3 * len) / 4);
    end
    listen = 1'b1;
    gap = int'($urandom_range(150, 10));
    repeat (gap) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 rstN = 1'b1;
    listen = 1'b1;
    @(negedge clk);
    checkOutput("reset valid", noteValid, 0);
    checkOutput("reset period", notePeriod, 0);
    checkOutput("reset duration", noteDuration, 0);
    checkOutput("reset index", noteIndex, 0);
    #1;

    $display("[TB] scenario 1: tone 11 then 21");
    dutNotes.delete();
    playTone(11, 400);
    playTone(21, 200);
    settle();
    checkOutput("t1 count", dutNotes.size(), 2);
    checkNote("t1 note0", 0, 10, 4, 0);
    checkNote("t1 note1", 1, 20, 2, 1);

    $display("[TB] scenario 2: glitch pair");
    dutNotes.delete();
    playTone(11, 198);
    waitToggle(1);
    waitToggle(2);
    waitToggle(8);
    playTone(11, 191);
    settle();
    checkOutput("t2 count", dutNotes.size(), 1);
    checkNote("t2 note0", 0, 10, 4, 2);
`ifdef BGM_DECODER_STATS_EN
    checkOutput("t2 glitch_cnt", glitchCnt, 2);
`endif

    $display("[TB] scenario 3: jitter 12/13");
    dutNotes.delete();
    begin
      int t, hp;
      t = 0;
      hp = 12;
      while (t + hp <= 300) begin
        waitToggle(hp);
        t += hp;
        hp = (hp == 12) ? 13 : 12;
      end
    end
    settle();
    checkOutput("t3 count", dutNotes.size(), 1);
    if (dutNotes.size() > 0) begin
      checkOutput("t3 period 11 or 12", (dutNotes[0].period == 11 || dutNotes[0].period == 12), 1);
      checkOutput("t3 duration", dutNotes[0].dur, 3);
    end

    $display("[TB] scenario 4: duration saturation");
    dutNotes.delete();
    playTone(11, 4000);
    settle();
    checkOutput("t4 count", dutNotes.size(), 1);
    checkNote("t4 note0", 0, 10, 31, 4);

    $display("[TB] scenario 5: listen drop");
    dutNotes.delete();
    fork
      playTone(11, 500);
      begin
        repeat (250) @(posedge clk);
        #1 listen = 1'b0;
        repeat (50) @(posedge clk);
        #1 listen = 1'b1;
      end
    join
    settle();
    checkOutput("t5 count", dutNotes.size(), 1);
    if (dutNotes.size() > 0) checkOutput("t5 period", dutNotes[0].period, 10);

    $display("[TB] scenario 6: reset mid-note");
    playTone(11, 200);
    @(negedge clk);
    #1 rstN = 1'b0;
    #1;
    checkOutput("t6 async valid", noteValid, 0);
    checkOutput("t6 async period", notePeriod, 0);
    checkOutput("t6 async duration", noteDuration, 0);
    checkOutput("t6 async index", noteIndex, 0);
`ifdef BGM_DECODER_STATS_EN
    checkOutput("t6 async glitch_cnt", glitchCnt, 0);
`endif
    repeat (3) @(negedge clk);
    #1 rstN = 1'b1;
    repeat (120) @(posedge clk);
    #1;
    dutNotes.delete();
    playTone(11, 200);
    settle();
    checkOutput("t6 count", dutNotes.size(), 1);
    checkNote("t6 note0", 0, 10, 2, 0);

    $display("[TB] random segments");
    for (int s = 0; s < 40; s++) applyStimulus();
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
